// File: rtl/pc_gen.sv
// IF-stage PC generator with priority trap/branch redirect, latched across stalls; redirect visible on pc next cycle.
// Request held stable until fetch_ready; optional tracing under PC_GEN_TRACE_EN.
module pc_gen #(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-3:0] RESET_VEC       = 'h0000BFF,
  parameter int                INC             = 1,
  parameter bit                REDIRECT_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              trap_valid,
  input  logic [ADDR_W-3:0] trap_target,
  input  logic              redir_valid,
  input  logic [ADDR_W-3:0] redir_target,
  input  logic              fetch_ready,
  output logic [ADDR_W-3:0] pc,
  output logic [ADDR_W-3:0] pc_next_seq,
  output logic              fetch_valid,
  output logic              redir_pending
);

  localparam int PW = ADDR_W - 2;

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;
  typedef enum logic [2:0] {
    SEL_HOLD, SEL_SEQ, SEL_PTRAP, SEL_LTRAP, SEL_PREDIR, SEL_LREDIR
  } sel_t;

  state_t          state;
  sel_t            sel;
  logic            pend_valid;
  logic            pend_is_trap;
  logic [PW-1:0]   pend_target;
  logic [PW-1:0]   apply_target;
  logic            apply;
  logic            fire;
  logic            can_apply;

  assign pc_next_seq   = pc + PW'(INC);
  assign fetch_valid   = (state == RUN) && !stall;
  assign fire          = fetch_valid && fetch_ready;
  assign redir_pending = pend_valid;
  assign can_apply     = (state != BOOT) && !stall;

  // A pending trap outranks a live trap; a live trap outranks any non-trap redirect.
  always_comb begin
    sel = SEL_HOLD;
    if (can_apply) begin
      if (pend_valid && pend_is_trap)
        sel = SEL_PTRAP;
      else if (trap_valid)
        sel = SEL_LTRAP;
      else if (pend_valid)
        sel = SEL_PREDIR;
      else if (redir_valid)
        sel = SEL_LREDIR;
      else if (fire)
        sel = SEL_SEQ;
    end
  end

  assign apply = (sel == SEL_PTRAP) || (sel == SEL_LTRAP) ||
                 (sel == SEL_PREDIR) || (sel == SEL_LREDIR);

  always_comb begin
    apply_target = pend_target;
    if (sel == SEL_LTRAP)
      apply_target = trap_target;
    else if (sel == SEL_LREDIR)
      apply_target = redir_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_VEC;
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
      pend_target  <= '0;
    end else if (apply) begin
      // The in-flight fetch is dropped: pc jumps, it does not also increment.
      pc           <= apply_target;
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
      state        <= REDIRECT_BUBBLE ? BUBBLE : RUN;
    end else begin
      state <= RUN;
      if (sel == SEL_SEQ)
        pc <= pc_next_seq;
      if (!can_apply) begin
        if (trap_valid) begin
          pend_valid   <= 1'b1;
          pend_is_trap <= 1'b1;
          pend_target  <= trap_target;
        end else if (redir_valid && !(pend_valid && pend_is_trap)) begin
          pend_valid   <= 1'b1;
          pend_is_trap <= 1'b0;
          pend_target  <= redir_target;
        end
      end
    end
  end

`ifdef PC_GEN_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (state == BOOT)
        $display("pc_gen: start");
      if (sel == SEL_SEQ)
        $display("pc_gen: fetch %h", {pc, 2'b00});
      else if (sel == SEL_PTRAP || sel == SEL_LTRAP)
        $display("pc_gen: trap %h", {apply_target, 2'b00});
      else if (apply)
        $display("pc_gen: redir %h", {apply_target, 2'b00});
    end
  end
`else
  // Tracing compiled out.
`endif

endmodule

// File: tb/tb_pc_gen.sv
`timescale 1ns/1ps
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, trap_valid, redir_valid, fetch_ready;
  logic [29:0] trap_target, redir_target;

  logic [29:0] d_pc   [2];
  logic [29:0] d_nseq [2];
  logic        d_fv   [2];
  logic        d_rp   [2];

  int checks = 0;
  int errors = 0;

  // Reference model: one per DUT (index 0 no bubble, index 1 with bubble).
  logic [29:0] m_pc   [2];
  logic [29:0] m_ptgt [2];
  bit          m_boot [2];
  bit          m_blank[2];
  bit          m_pv   [2];
  bit          m_pt   [2];

  always #5 clk = ~clk;

  pc_gen #(.REDIRECT_BUBBLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .fetch_ready(fetch_ready),
    .pc(d_pc[0]), .pc_next_seq(d_nseq[0]),
    .fetch_valid(d_fv[0]), .redir_pending(d_rp[0])
  );

  pc_gen #(.REDIRECT_BUBBLE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .fetch_ready(fetch_ready),
    .pc(d_pc[1]), .pc_next_seq(d_nseq[1]),
    .fetch_valid(d_fv[1]), .redir_pending(d_rp[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]    = 30'h0000BFF;
      m_ptgt[k]  = '0;
      m_boot[k]  = 1'b1;
      m_blank[k] = 1'b0;
      m_pv[k]    = 1'b0;
      m_pt[k]    = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit          fv;
      bit          have;
      logic [29:0] tgt;
      fv = !m_boot[k] && !m_blank[k] && !stall;
      if (!m_boot[k] && !stall) begin
        have = 1'b1;
        if (m_pv[k] && m_pt[k])  tgt = m_ptgt[k];
        else if (trap_valid)     tgt = trap_target;
        else if (m_pv[k])        tgt = m_ptgt[k];
        else if (redir_valid)    tgt = redir_target;
        else begin have = 1'b0; tgt = '0; end
        if (have) begin
          m_pc[k]    = tgt;
          m_pv[k]    = 1'b0;
          m_pt[k]    = 1'b0;
          m_blank[k] = (k == 1);
        end else begin
          if (fv && fetch_ready) m_pc[k] = m_pc[k] + 30'd1;
          m_blank[k] = 1'b0;
        end
      end else begin
        if (trap_valid) begin
          m_pv[k] = 1'b1; m_pt[k] = 1'b1; m_ptgt[k] = trap_target;
        end else if (redir_valid && !(m_pv[k] && m_pt[k])) begin
          m_pv[k] = 1'b1; m_pt[k] = 1'b0; m_ptgt[k] = redir_target;
        end
        m_boot[k]  = 1'b0;
        m_blank[k] = 1'b0;
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared 1ns later, then the model advances with the edge.
  task automatic cycle();
    logic [29:0] nseq;
    #1;
    if (!reset) model_reset();
    for (int k = 0; k < 2; k++) begin
      nseq = m_pc[k] + 30'd1;
      check($sformatf("pc%0d", k), {2'b00, d_pc[k]}, {2'b00, m_pc[k]});
      check($sformatf("pc_next_seq%0d", k), {2'b00, d_nseq[k]}, {2'b00, nseq});
      check($sformatf("fetch_valid%0d", k), 32'(d_fv[k]),
            32'(!m_boot[k] && !m_blank[k] && !stall));
      check($sformatf("redir_pending%0d", k), 32'(d_rp[k]), 32'(m_pv[k]));
    end
    if (reset) model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; trap_valid = 1'b0; redir_valid = 1'b0;
    fetch_ready = 1'b0; trap_target = '0; redir_target = '0;
    model_reset();
    @(negedge clk);

    // Reset held three cycles, then boot with memory ready.
    repeat (3) cycle();
    check("reset_pc", {2'b00, d_pc[0]}, 32'h0000BFF);
    check("reset_fv", 32'(d_fv[0]), 32'd0);
    reset = 1'b1; fetch_ready = 1'b1;
    repeat (3) cycle();
    #1 check("boot_pc_c01", {2'b00, d_pc[0]}, 32'h00000C01);

    // Backpressure at 0xC01.
    fetch_ready = 1'b0;
    repeat (4) cycle();
    fetch_ready = 1'b1;
    cycle();
    #1 check("bp_step_c02", {2'b00, d_pc[0]}, 32'h00000C02);

    // Redirect then trap while stalled; trap must win on release.
    stall = 1'b1;
    redir_valid = 1'b1; redir_target = 30'h100;
    cycle();
    redir_valid = 1'b0;
    #1 check("stall_pending", 32'(d_rp[0]), 32'd1);
    cycle();
    trap_valid = 1'b1; trap_target = 30'h2000;
    cycle();
    trap_valid = 1'b0;
    cycle();
    stall = 1'b0;
    cycle();
    #1 check("stall_trap_pc", {2'b00, d_pc[0]}, 32'h00002000);
    cycle();

    // Simultaneous live trap and redirect.
    trap_valid = 1'b1; trap_target = 30'h40;
    redir_valid = 1'b1; redir_target = 30'h80;
    cycle();
    trap_valid = 1'b0; redir_valid = 1'b0;
    #1 check("simul_pc0", {2'b00, d_pc[0]}, 32'h40);
    check("simul_pc1", {2'b00, d_pc[1]}, 32'h40);
    cycle();

    // Bubble after redirect on the bubble-enabled instance.
    redir_valid = 1'b1; redir_target = 30'h300;
    cycle();
    redir_valid = 1'b0;
    #1 check("bubble_pc", {2'b00, d_pc[1]}, 32'h300);
    check("bubble_fv0", 32'(d_fv[1]), 32'd0);
    cycle();
    #1 check("bubble_fv1", 32'(d_fv[1]), 32'd1);

    // Wrap from the top word address.
    fetch_ready = 1'b0;
    cycle();
    redir_valid = 1'b1; redir_target = 30'h3FFFFFFF; fetch_ready = 1'b1;
    cycle();
    redir_valid = 1'b0;
    cycle();
    #1 check("wrap_pc", {2'b00, d_pc[0]}, 32'h0);
    repeat (2) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      stall        = ($urandom_range(0, 3) == 0);
      trap_valid   = ($urandom_range(0, 19) == 0);
      redir_valid  = ($urandom_range(0, 9) == 0);
      fetch_ready  = ($urandom_range(0, 9) < 7);
      trap_target  = 30'($urandom);
      redir_target = 30'($urandom);
      cycle();
    end
    trap_valid = 1'b0; redir_valid = 1'b0;

    // Asynchronous reset between edges with a redirect pending.
    stall = 1'b1;
    redir_valid = 1'b1; redir_target = 30'h1234;
    cycle();
    redir_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check("areset_pc0", {2'b00, d_pc[0]}, 32'h0000BFF);
    check("areset_rp0", 32'(d_rp[0]), 32'd0);
    check("areset_pc1", {2'b00, d_pc[1]}, 32'h0000BFF);
    check("areset_rp1", 32'(d_rp[1]), 32'd0);
    @(negedge clk);
    repeat (2) cycle();
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
